rr_timeout_arbiter: RTL and testbench

//  Parametrised N-port output-channel arbiter for the NoC router. Grants one input port at a time

---
 rtl/noc_arb_pkg.sv | 12 +
 rtl/port_timeout_timer.sv | 38 +++
 rtl/rr_timeout_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_timeout_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output-channel arbiter: flit-id encodings and arbiter states.
package noc_arb_pkg;

  localparam logic [2:0] HEAD_ID = 3'b001;
  localparam logic [2:0] TAIL_ID = 3'b100;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

endpackage

// File: rtl/port_timeout_timer.sv
// Per-port packet watchdog: latches the head-flit length and counts cycles the port holds grant.
module port_timeout_timer #(
  parameter int unsigned      LEN_W   = 12,
  parameter int unsigned      FID_W   = 3,
  parameter logic [FID_W-1:0] HEAD_ID = noc_arb_pkg::HEAD_ID
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [FID_W-1:0] flit_id,
  input  logic [LEN_W-1:0] length,
  input  logic             grant,
  output logic             timesup
);

  logic [LEN_W-1:0] limit_q;
  logic [LEN_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      limit_q <= '0;
      count_q <= '0;
    end else begin
      if (req && (flit_id == HEAD_ID)) begin
        limit_q <= length;
      end
      if (!grant) begin
        count_q <= '0;
      end else if (count_q != '1) begin
        count_q <= count_q + LEN_W'(1);
      end
    end
  end

  // limit - 1 is only meaningful when limit is non-zero; zero disables the watchdog.
  assign timesup = (limit_q != '0) && (count_q >= (limit_q - LEN_W'(1)));

endmodule

// File: rtl/rr_timeout_arbiter.sv
// Round-robin output-channel arbiter with per-port length watchdog and tail-flit early release.
module rr_timeout_arbiter #(
  parameter int unsigned      NPORTS  = 5,
  parameter int unsigned      LEN_W   = 12,
  parameter int unsigned      FID_W   = 3,
  parameter logic [FID_W-1:0] HEAD_ID = noc_arb_pkg::HEAD_ID,
  parameter logic [FID_W-1:0] TAIL_ID = noc_arb_pkg::TAIL_ID
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORTS-1:0]         req,
  input  logic [NPORTS*FID_W-1:0]   flit_id,
  input  logic [NPORTS*LEN_W-1:0]   length,
  output logic [NPORTS-1:0]         grant,
  output logic                      grant_valid,
  output logic [$clog2(NPORTS)-1:0] grant_idx,
  output logic [NPORTS-1:0]         timeout
);
  import noc_arb_pkg::*;

  localparam int unsigned IdxW = $clog2(NPORTS);

  arb_state_e        state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [NPORTS-1:0] timeout_q, timeout_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;

  logic [FID_W-1:0]  fid [NPORTS];
  logic [NPORTS-1:0] timesup;

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    assign fid[i] = flit_id[i*FID_W +: FID_W];

    port_timeout_timer #(
      .LEN_W   (LEN_W),
      .FID_W   (FID_W),
      .HEAD_ID (HEAD_ID)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .req     (req[i]),
      .flit_id (fid[i]),
      .length  (length[i*LEN_W +: LEN_W]),
      .grant   (grant_q[i]),
      .timesup (timesup[i])
    );
  end

  // Search starts just past the pointer; the current owner is masked so it cannot re-win
  // on release (grant_q is zero in idle, so nothing is masked there).
  logic [NPORTS-1:0]   masked;
  logic [2*NPORTS-1:0] dbl;
  logic [NPORTS-1:0]   rot;
  logic                found;
  int unsigned         start, win_off, win;
  logic [IdxW-1:0]     win_idx;

  always_comb begin
    masked  = req & ~grant_q;
    start   = int'(ptr_q) + 1;
    dbl     = {masked, masked} >> start;
    rot     = dbl[NPORTS-1:0];
    found   = 1'b0;
    win_off = 0;
    for (int j = 0; j < NPORTS; j++) begin
      if (!found && rot[j]) begin
        found   = 1'b1;
        win_off = j;
      end
    end
    win     = (start + win_off) % NPORTS;
    win_idx = IdxW'(win);
  end

  logic owner_req, owner_tail, owner_tout, release_own, timeout_fire, arbitrate;

  always_comb begin
    owner_req    = req[idx_q];
    owner_tail   = owner_req && (fid[idx_q] == TAIL_ID);
    owner_tout   = timesup[idx_q];
    release_own  = !owner_req || owner_tail || owner_tout;
    // Tail wins over a coincident timeout, so the pulse is suppressed.
    timeout_fire = (state_q == ARB_BUSY) && owner_req && !owner_tail && owner_tout;
    arbitrate    = (state_q == ARB_IDLE) || release_own;
    state_d      = state_q;
    unique case (state_q)
      ARB_IDLE: if (found) state_d = ARB_BUSY;
      ARB_BUSY: if (release_own) state_d = found ? ARB_BUSY : ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    timeout_d = '0;
    if (arbitrate) begin
      if (found) begin
        grant_d = NPORTS'(1) << win_idx;
        idx_d   = win_idx;
        ptr_d   = win_idx;
      end else begin
        grant_d = '0;
        idx_d   = '0;
      end
    end
    timeout_d[idx_q] = timeout_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= IdxW'(NPORTS - 1);
      timeout_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = idx_q;
  assign timeout     = timeout_q;

`ifndef SYNTHESIS
  grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
`endif

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Directed bench for rr_timeout_arbiter: reset, round-robin order, watchdog, tail handling.
module tb_rr_timeout_arbiter;

  localparam int unsigned NPORTS = 5;
  localparam int unsigned LEN_W  = 12;
  localparam int unsigned FID_W  = 3;
  localparam logic [FID_W-1:0] HEAD = 3'b001;
  localparam logic [FID_W-1:0] TAIL = 3'b100;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [NPORTS-1:0]       req = '0;
  logic [NPORTS*FID_W-1:0] flit_id = '0;
  logic [NPORTS*LEN_W-1:0] length = '0;
  logic [NPORTS-1:0]       grant;
  logic                    grant_valid;
  logic [2:0]              grant_idx;
  logic [NPORTS-1:0]       timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_timeout_arbiter #(
    .NPORTS  (NPORTS),
    .LEN_W   (LEN_W),
    .FID_W   (FID_W),
    .HEAD_ID (HEAD),
    .TAIL_ID (TAIL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flit_id     (flit_id),
    .length      (length),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fid(input int p, input logic [FID_W-1:0] v);
    flit_id[p*FID_W +: FID_W] = v;
  endtask

  task automatic set_len(input int p, input logic [LEN_W-1:0] v);
    length[p*LEN_W +: LEN_W] = v;
  endtask

  task automatic do_reset();
    req     = '0;
    flit_id = '0;
    length  = '0;
    rst     = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset mid-grant, then confirm port 0 has first priority.
    do_reset();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(grant_valid), 32'h0);
    req = 5'b00100;
    step();
    check("pre_rst_grant", 32'(grant), 32'h04);
    step();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_valid", 32'(grant_valid), 32'h0);
    check("mid_rst_tout", 32'(timeout), 32'h0);
    check("mid_rst_idx", 32'(grant_idx), 32'h0);
    step();
    rst = 1'b0;
    req = 5'b11111;
    step();
    check("post_rst_grant", 32'(grant), 32'h01);
    check("post_rst_idx", 32'(grant_idx), 32'h0);

    // Round robin: each owner sees a body flit then a tail flit.
    do_reset();
    req = 5'b11111;
    for (int j = 0; j < 6; j++) begin
      int p;
      p = j % NPORTS;
      step();
      check("rr_grant_a", 32'(grant), 32'(1) << p);
      check("rr_idx", 32'(grant_idx), 32'(p));
      flit_id = '0;
      step();
      check("rr_grant_b", 32'(grant), 32'(1) << p);
      set_fid(p, TAIL);
    end

    // Timeout with a waiting requester: port 2 holds exactly 4 cycles, port 3 follows.
    do_reset();
    req = 5'b01100;
    set_fid(2, HEAD);
    set_len(2, 12'd4);
    step();
    check("to_grant_1", 32'(grant), 32'h04);
    flit_id = '0;
    for (int c = 2; c <= 4; c++) begin
      step();
      check("to_grant_hold", 32'(grant), 32'h04);
      check("to_no_pulse", 32'(timeout), 32'h0);
    end
    step();
    check("to_handoff", 32'(grant), 32'h08);
    check("to_pulse", 32'(timeout), 32'h04);
    check("to_idx", 32'(grant_idx), 32'h3);
    step();
    check("to_pulse_end", 32'(timeout), 32'h0);

    // Timeout with nobody else waiting: idle cycle, then port 2 re-granted from idle.
    do_reset();
    req = 5'b00100;
    set_fid(2, HEAD);
    set_len(2, 12'd4);
    step();
    flit_id = '0;
    for (int c = 2; c <= 4; c++) step();
    check("to_idle_hold", 32'(grant), 32'h04);
    step();
    check("to_idle_grant", 32'(grant), 32'h0);
    check("to_idle_valid", 32'(grant_valid), 32'h0);
    check("to_idle_pulse", 32'(timeout), 32'h04);
    step();
    check("to_regrant", 32'(grant), 32'h04);
    check("to_regrant_pulse", 32'(timeout), 32'h0);

    // Length 0 disables the watchdog.
    do_reset();
    req = 5'b00010;
    set_fid(1, HEAD);
    set_len(1, 12'd0);
    step();
    flit_id = '0;
    for (int c = 0; c < 100; c++) begin
      check("len0_grant", 32'(grant), 32'h02);
      check("len0_tout", 32'(timeout), 32'h0);
      step();
    end

    // Wrap and exclusion: port 4 owner times out, port 0 wins without an idle cycle.
    do_reset();
    req = 5'b10000;
    set_fid(4, HEAD);
    set_len(4, 12'd3);
    step();
    check("wrap_grant4", 32'(grant), 32'h10);
    check("wrap_idx4", 32'(grant_idx), 32'h4);
    flit_id = '0;
    req = 5'b10001;
    step();
    step();
    check("wrap_hold", 32'(grant), 32'h10);
    step();
    check("wrap_grant0", 32'(grant), 32'h01);
    check("wrap_valid", 32'(grant_valid), 32'h1);
    check("wrap_pulse", 32'(timeout), 32'h10);

    // Tail and timeout in the same cycle: released as tail, no pulse.
    do_reset();
    req = 5'b01000;
    set_fid(3, HEAD);
    set_len(3, 12'd2);
    step();
    check("tt_grant1", 32'(grant), 32'h08);
    flit_id = '0;
    step();
    check("tt_grant2", 32'(grant), 32'h08);
    set_fid(3, TAIL);
    step();
    check("tt_release", 32'(grant), 32'h0);
    check("tt_no_pulse", 32'(timeout), 32'h0);

    // Request withdrawal releases the grant.
    do_reset();
    req = 5'b00001;
    step();
    check("drop_grant", 32'(grant), 32'h01);
    req = '0;
    step();
    check("drop_release", 32'(grant), 32'h0);
    check("drop_no_pulse", 32'(timeout), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
